// File: rtl/ntt_pkg.sv
// Shared types and defaults for the NTT pointwise datapath.
// Used by the stream buffer, its serializer and the multiplier.
package ntt_pkg;

    localparam int N_DEF     = 256;
    localparam int WIDTH_DEF = 32;
    localparam int Q_DEF     = 3329;

    typedef logic [WIDTH_DEF-1:0] coeff_t;

    typedef enum logic {
        FILL,
        FULL
    } load_state_e;

    typedef enum logic {
        IDLE,
        ACTIVE
    } drain_state_e;

endpackage

// File: rtl/ntt_coeff_serializer.sv
// Result bank and drain FSM: captures the N-wide product on a strobe,
// then streams it out one coefficient per valid/ready handshake.
module ntt_coeff_serializer
    import ntt_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_capture,
    input  logic [N-1:0][WIDTH-1:0]   i_data,
    input  logic                      i_ready,
    output logic                      o_valid,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_last,
    output logic                      o_idle
);

    localparam int IW = $clog2(N);

    drain_state_e              r_dstate;
    drain_state_e              w_dstate_nxt;
    logic [IW-1:0]             r_ridx;
    logic [IW-1:0]             w_ridx_nxt;
    logic [N-1:0][WIDTH-1:0]   r_res;
    logic                      w_hs;
    logic                      w_ridx_last;

    assign w_hs        = o_valid && i_ready;
    assign w_ridx_last = (r_ridx == IW'(N-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dstate <= IDLE;
            r_ridx   <= '0;
        end else begin
            r_dstate <= w_dstate_nxt;
            r_ridx   <= w_ridx_nxt;
        end
    end

    always_comb begin
        w_dstate_nxt = r_dstate;
        w_ridx_nxt   = r_ridx;
        unique case (r_dstate)
            IDLE: begin
                if (i_capture) begin
                    w_dstate_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_hs) begin
                    if (w_ridx_last) begin
                        w_ridx_nxt   = '0;
                        w_dstate_nxt = IDLE;
                    end else begin
                        w_ridx_nxt = r_ridx + 1'b1;
                    end
                end
            end
        endcase
    end

    // The top only strobes capture while this side is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else if (i_capture) begin
            r_res <= i_data;
        end
    end

    assign o_valid = (r_dstate == ACTIVE);
    assign o_idle  = (r_dstate == IDLE);
    assign o_data  = r_res[r_ridx];
    assign o_last  = o_valid && w_ridx_last;

endmodule

// File: rtl/ntt_pointwise_stream_buffer.sv
// Stream front/back end for the pointwise multiplier: fills A/B banks,
// hands them to the multiplier, captures and drains the product.
module ntt_pointwise_stream_buffer
    import ntt_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int Q     = Q_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_a,
    input  logic [WIDTH-1:0]          in_b,
    output logic [N-1:0][WIDTH-1:0]   poly_a,
    output logic [N-1:0][WIDTH-1:0]   poly_b,
    input  logic [N-1:0][WIDTH-1:0]   poly_c,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic                      range_err,
    input  logic                      err_clr
);

    localparam int IW = $clog2(N);

    load_state_e               r_lstate;
    load_state_e               w_lstate_nxt;
    logic [IW-1:0]             r_idx;
    logic [IW-1:0]             w_idx_nxt;
    logic [N-1:0][WIDTH-1:0]   r_bank_a;
    logic [N-1:0][WIDTH-1:0]   r_bank_b;
    logic                      r_range_err;
    logic                      w_accept;
    logic                      w_capture;
    logic                      w_drain_idle;
    logic                      w_out_of_range;

    assign in_ready       = (r_lstate == FILL);
    assign w_accept       = in_valid && in_ready;
    assign w_capture      = (r_lstate == FULL) && w_drain_idle;
    assign w_out_of_range = (in_a >= WIDTH'(Q)) || (in_b >= WIDTH'(Q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lstate <= FILL;
            r_idx    <= '0;
        end else begin
            r_lstate <= w_lstate_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    always_comb begin
        w_lstate_nxt = r_lstate;
        w_idx_nxt    = r_idx;
        unique case (r_lstate)
            FILL: begin
                if (w_accept) begin
                    if (r_idx == IW'(N-1)) begin
                        w_idx_nxt    = '0;
                        w_lstate_nxt = FULL;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            FULL: begin
                if (w_capture) begin
                    w_lstate_nxt = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_a <= '0;
            r_bank_b <= '0;
        end else if (w_accept) begin
            r_bank_a[r_idx] <= in_a;
            r_bank_b[r_idx] <= in_b;
        end
    end

    // Out-of-range beats are still stored; the flag only reports them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (err_clr) begin
            r_range_err <= 1'b0;
        end else if (w_accept && w_out_of_range) begin
            r_range_err <= 1'b1;
        end
    end

    assign poly_a    = r_bank_a;
    assign poly_b    = r_bank_b;
    assign range_err = r_range_err;

    ntt_coeff_serializer #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_capture (w_capture),
        .i_data    (poly_c),
        .i_ready   (out_ready),
        .o_valid   (out_valid),
        .o_data    (out_data),
        .o_last    (out_last),
        .o_idle    (w_drain_idle)
    );

endmodule

// File: tb/tb_ntt_pointwise_stream_buffer.sv
// Scoreboard bench: loads are modelled as a*b mod Q per beat and the
// expected stream is queued; a monitor compares every output handshake.
module tb_ntt_pointwise_stream_buffer;

    localparam int N = 256;
    localparam int W = 32;
    localparam int Q = 3329;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [W-1:0]          in_a = '0;
    logic [W-1:0]          in_b = '0;
    logic [N-1:0][W-1:0]   poly_a;
    logic [N-1:0][W-1:0]   poly_b;
    logic [N-1:0][W-1:0]   poly_c;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [W-1:0]          out_data;
    logic                  out_last;
    logic                  range_err;
    logic                  err_clr = 1'b0;

    int compared = 0;
    int mismatched = 0;
    int rdy_mode = 0;
    bit hold = 0;
    logic [W-1:0] expq[$];
    logic [W-1:0] pending[$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            poly_c[i] = W'((64'(poly_a[i]) * 64'(poly_b[i])) % 64'(Q));
        end
    end

    ntt_pointwise_stream_buffer #(.N(N), .WIDTH(W), .Q(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .poly_a    (poly_a),
        .poly_b    (poly_b),
        .poly_c    (poly_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .range_err (range_err),
        .err_clr   (err_clr)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        return W'((64'(a) * 64'(b)) % 64'(Q));
    endfunction

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic clr);
        int n = 0;
        bit ok = 0;
        while (!ok && n < 4000) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = a;
            in_b = b;
            err_clr = clr;
            ok = in_ready;
            @(posedge clk);
            n++;
        end
        if (!ok) begin
            check("send_timeout", 64'(ok), 64'd1);
        end else begin
            pending.push_back(model(a, b));
            if (pending.size() == N) begin
                foreach (pending[i]) expq.push_back(pending[i]);
                pending.delete();
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic load_random(input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) go_idle();
            send_beat(W'($urandom_range(0, Q-1)),
                      W'($urandom_range(0, Q-1)), 1'b0);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((expq.size() != 0 || out_valid) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold) out_ready = 1'b0;
            else if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ~out_ready;
            else out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int beat = 0;
        bit prev_stall = 0;
        logic [W-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                beat = 0;
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_data", 64'(out_data), 64'(prev_data));
                    check("stall_last", 64'(out_last), 64'(prev_last));
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL extra_beat: got %0h expected none",
                                 out_data);
                    end else begin
                        e = expq.pop_front();
                        check("out_data", 64'(out_data), 64'(e));
                        check("out_last", 64'(out_last), 64'(beat == N-1));
                    end
                    beat = (beat == N-1) ? 0 : beat + 1;
                end
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
                prev_last = out_last;
            end
        end
    end

    initial begin
        logic [W-1:0] snap_d;
        logic snap_l;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_range_err", 64'(range_err), 64'd0);
        check("rst_poly_a0", 64'(poly_a[0]), 64'd0);
        check("rst_poly_bN", 64'(poly_b[N-1]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Ramp load with fixed latency
        for (int i = 0; i < N; i++) send_beat(W'(i), W'(2), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("lat_no_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_first", 64'(out_data), 64'd0);
        wait_drain();

        // Drain-last coincides with load-full
        load_random(1'b0);
        load_random(1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("coin_gap_valid", 64'(out_valid), 64'd0);
        check("coin_in_ready", 64'(in_ready), 64'd0);
        check("coin_queued", 64'(expq.size()), 64'(N));
        @(negedge clk);
        check("coin_capture", 64'(out_valid), 64'd1);

        // Backpressure mid-drain
        repeat (50) @(negedge clk);
        hold = 1;
        @(posedge clk);
        #2;
        snap_d = out_data;
        snap_l = out_last;
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", 64'(out_data), 64'(snap_d));
            check("bp_last", 64'(out_last), 64'(snap_l));
        end
        hold = 0;
        wait_drain();

        // Overlapped loads with toggling ready
        rdy_mode = 1;
        load_random(1'b0);
        load_random(1'b0);
        #1;
        check("b2b_full", 64'(in_ready), 64'd0);
        load_random(1'b0);
        go_idle();
        wait_drain();
        rdy_mode = 0;

        // Range flag set, hold, clear and clear-priority
        for (int i = 0; i < N; i++) begin
            if (i == 5) send_beat(W'(Q), W'(7), 1'b0);
            else if (i == 30) send_beat(W'(1), W'(1), 1'b1);
            else if (i == 40) send_beat(W'(5000), W'(1), 1'b1);
            else if (i == 41) send_beat(W'(1), W'(4000), 1'b0);
            else send_beat(W'($urandom_range(0, Q-1)), W'(3), 1'b0);
            #1;
            if (i == 4) check("rng_clean", 64'(range_err), 64'd0);
            if (i == 5) check("rng_set", 64'(range_err), 64'd1);
            if (i == 20) check("rng_sticky", 64'(range_err), 64'd1);
            if (i == 30) check("rng_clear", 64'(range_err), 64'd0);
            if (i == 40) check("rng_clr_prio", 64'(range_err), 64'd0);
            if (i == 41) check("rng_set_b", 64'(range_err), 64'd1);
        end
        go_idle();
        wait_drain();

        // Reset in the middle of a load
        rdy_mode = 2;
        load_random(1'b0);
        for (int i = 0; i < 100; i++)
            send_beat(W'($urandom_range(0, Q-1)),
                      W'($urandom_range(0, Q-1)), 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        pending.delete();
        expq.delete();
        repeat (2) @(negedge clk);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_err", 64'(range_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        repeat (20) @(negedge clk);
        check("no_stale_valid", 64'(out_valid), 64'd0);
        load_random(1'b1);
        load_random(1'b1);
        go_idle();
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
